truth_table_lut: RTL and testbench

Runtime-programmable N-input, single-output truth-table evaluator for the netlist-synthesis flow. It replaces one fixed 4-input case-table module per Boolean function. The 2^N-entry table is loaded serially into a shadow register and committed atomically. Inputs are then evaluated with a registered output, and a built-in sweep mode streams every table entry in address order so benches and downstream checkers can compare the programmed function against a synthesized netlist.

---
 rtl/truth_table_lut.sv | 139 +++++++++++++
 tb/tb_truth_table_lut.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_lut.sv
// Purpose : runtime-programmable N-input truth table; serial shadow load with atomic commit, registered eval, full-table sweep.
// Latency : eval 1 cycle (inp/eval_en -> out/out_valid); sweep beat 0 one cycle after the start is taken, D beats total.
// Backpressure: cfg_ready low only while a sweep owns the block; eval is never stalled; sweep_start outside IDLE is dropped.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_valid/cfg_bit/cfg_ready     serial table load, address 0 first; cfg_done pulses after the D-th bit
//   inp, eval_en -> out, out_valid  registered lookup of the active table
//   sweep_start -> sweep_busy/_valid/_addr/_bit/_done   streams the active table in address order
module truth_table_lut #(
  parameter int N_INPUTS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  output logic                cfg_ready,
  output logic                cfg_done,
  input  logic [N_INPUTS-1:0] inp,
  input  logic                eval_en,
  output logic                out,
  output logic                out_valid,
  input  logic                sweep_start,
  output logic                sweep_busy,
  output logic                sweep_valid,
  output logic [N_INPUTS-1:0] sweep_addr,
  output logic                sweep_bit,
  output logic                sweep_done
);

  localparam int D  = 1 << N_INPUTS;
  localparam int CW = N_INPUTS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [D-1:0]        shadow;
  logic [D-1:0]        active;
  logic [D-1:0]        shadow_nxt;
  logic [N_INPUTS-1:0] sweep_ptr;
  logic                cfg_acc;
  logic                last_bit;

  assign cfg_ready = (state != SWEEP);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign last_bit  = (cnt == CW'(D - 1));

  // Shadow with the incoming bit merged in; the commit copies this so the
  // final bit lands in the active table on the same edge it is accepted.
  // In IDLE cnt is always 0, so the first bit goes to entry 0.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[cnt[N_INPUTS-1:0]] = cfg_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      active      <= '0;
      cfg_done    <= 1'b0;
      sweep_ptr   <= '0;
      sweep_busy  <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_addr  <= '0;
      sweep_bit   <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          // A load beats a simultaneous sweep request; the request is lost.
          if (cfg_acc) begin
            shadow <= shadow_nxt;
            cnt    <= CW'(1);
            state  <= LOAD;
          end else if (sweep_start) begin
            sweep_ptr <= '0;
            state     <= SWEEP;
          end
        end

        LOAD: begin
          if (cfg_acc) begin
            shadow <= shadow_nxt;
            if (last_bit) begin
              active   <= shadow_nxt;
              cnt      <= '0;
              cfg_done <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        SWEEP: begin
          // The first edge in SWEEP emits beat 0; the edge after the beat
          // flagged done retires the sweep, so busy spans exactly D cycles.
          if (sweep_done) begin
            sweep_busy  <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_done  <= 1'b0;
            state       <= IDLE;
          end else begin
            sweep_busy  <= 1'b1;
            sweep_valid <= 1'b1;
            sweep_addr  <= sweep_ptr;
            sweep_bit   <= active[sweep_ptr];
            sweep_done  <= (sweep_ptr == N_INPUTS'(D - 1));
            sweep_ptr   <= sweep_ptr + N_INPUTS'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Evaluation reads the active table before any commit on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= eval_en;
      if (eval_en) begin
        out <= active[inp];
      end
    end
  end

endmodule

// File: tb/tb_truth_table_lut.sv
module tb_truth_table_lut;

  parameter int N = 4;
  localparam int D = 1 << N;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_ready;
  logic         cfg_done;
  logic [N-1:0] inp;
  logic         eval_en;
  logic         out;
  logic         out_valid;
  logic         sweep_start;
  logic         sweep_busy;
  logic         sweep_valid;
  logic [N-1:0] sweep_addr;
  logic         sweep_bit;
  logic         sweep_done;

  truth_table_lut #(.N_INPUTS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .inp         (inp),
    .eval_en     (eval_en),
    .out         (out),
    .out_valid   (out_valid),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_valid (sweep_valid),
    .sweep_addr  (sweep_addr),
    .sweep_bit   (sweep_bit),
    .sweep_done  (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the committed table plus the list of bits received so far.
  logic [D-1:0] m_a;
  bit           m_bits[$];
  logic         exp_out;
  logic         exp_ov;
  logic         exp_done;

  // Advance one clock edge, updating the model from the inputs presented
  // during the cycle. Eval reads the table as it was before this edge.
  task automatic tick();
    exp_done = 1'b0;
    exp_ov   = eval_en;
    if (eval_en) exp_out = m_a[inp];
    if (cfg_valid) begin
      m_bits.push_back(cfg_bit);
      if (m_bits.size() == D) begin
        for (int i = 0; i < D; i++) m_a[i] = m_bits[i];
        m_bits.delete();
        exp_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; eval_en = 1'b0; inp = '0; sweep_start = 1'b0;
    m_a = '0; m_bits.delete(); exp_out = 1'b0; exp_ov = 1'b0; exp_done = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [N+6:0] got, exp;
    rst_n = 1'b1;
    cfg_valid = 1'b0; cfg_bit = 1'b0; eval_en = 1'b0; inp = '0; sweep_start = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    got = {out, out_valid, cfg_done, cfg_ready, sweep_busy, sweep_valid, sweep_addr, sweep_bit, sweep_done};
    exp = {4'b0001, 2'b00, {N{1'b0}}, 2'b00};
    n_checks++;
    if (got !== exp) $display("FAIL reset_outputs: got %b expected %b", got, exp);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_sweep(input string name, input bit restart);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    n_checks++;
    if ({sweep_busy, sweep_valid} !== 2'b00)
      $display("FAIL %s_early: busy/valid=%b%b expected 00", name, sweep_busy, sweep_valid);
    else n_pass++;
    for (int k = 0; k < D; k++) begin
      logic [N-1:0] ka;
      ka = k[N-1:0];
      if (restart && k == D / 2) sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      n_checks++;
      if ({sweep_busy, sweep_valid, sweep_addr, sweep_bit, sweep_done} !== {2'b11, ka, m_a[k], (k == D - 1)})
        $display("FAIL %s_beat%0d: busy/valid=%b%b addr=%0d bit=%b done=%b expected addr=%0d bit=%b done=%b",
                 name, k, sweep_busy, sweep_valid, sweep_addr, sweep_bit, sweep_done, ka, m_a[k], (k == D - 1));
      else n_pass++;
      n_checks++;
      if (cfg_ready !== 1'b0) $display("FAIL %s_cfg_ready_beat%0d: got %b expected 0", name, k, cfg_ready);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({sweep_busy, sweep_valid, sweep_done, cfg_ready} !== 4'b0001)
      $display("FAIL %s_end: busy/valid/done/ready=%b%b%b%b expected 0001", name,
               sweep_busy, sweep_valid, sweep_done, cfg_ready);
    else n_pass++;
  endtask

  task automatic test_eval_random(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      eval_en = 1'($urandom);
      inp = N'($urandom);
      tick();
      n_checks++;
      if ({out_valid, out} !== {exp_ov, exp_out})
        $display("FAIL %s_cycle%0d: out_valid/out=%b%b expected %b%b", name, c, out_valid, out, exp_ov, exp_out);
      else n_pass++;
    end
    eval_en = 1'b0;
  endtask

  task automatic test_load(input logic [255:0] pat, input string name);
    int done_seen;
    done_seen = 0;
    for (int b = 0; b < D; b++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g <= gaps; g++) begin
        cfg_valid = (g == gaps);
        cfg_bit = (g == gaps) ? pat[b] : 1'($urandom);
        eval_en = 1'($urandom);
        inp = N'($urandom);
        tick();
        if (cfg_done === 1'b1) done_seen++;
        n_checks++;
        if ({out_valid, out, cfg_done, cfg_ready} !== {exp_ov, exp_out, exp_done, 1'b1})
          $display("FAIL %s_bit%0d: ov/out/done/ready=%b%b%b%b expected %b%b%b1", name, b,
                   out_valid, out, cfg_done, cfg_ready, exp_ov, exp_out, exp_done);
        else n_pass++;
      end
    end
    cfg_valid = 1'b0;
    eval_en = 1'b0;
    tick();
    if (cfg_done === 1'b1) done_seen++;
    n_checks++;
    if (done_seen !== 1) $display("FAIL %s_done_count: got %0d expected 1", name, done_seen);
    else n_pass++;
    for (int a = 0; a < D; a++) begin
      eval_en = 1'b1;
      inp = N'(a);
      tick();
      n_checks++;
      if ({out_valid, out} !== {1'b1, pat[a]})
        $display("FAIL %s_eval%0d: out_valid/out=%b%b expected 1%b", name, a, out_valid, out, pat[a]);
      else n_pass++;
    end
    eval_en = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out} !== {1'b0, pat[D-1]})
      $display("FAIL %s_hold: out_valid/out=%b%b expected 0%b", name, out_valid, out, pat[D-1]);
    else n_pass++;
  endtask

  // Continuous eval on one address across the commit edge of a fresh load.
  task automatic test_commit_boundary(input logic [255:0] pat);
    int a;
    logic old_bit;
    a = 0;
    for (int i = D - 1; i >= 0; i--) if (pat[i]) a = i;
    old_bit = m_a[a];
    eval_en = 1'b1;
    inp = N'(a);
    for (int b = 0; b < D; b++) begin
      cfg_valid = 1'b1;
      cfg_bit = pat[b];
      tick();
      n_checks++;
      if ({out_valid, out} !== {exp_ov, exp_out})
        $display("FAIL commit_cycle%0d: out_valid/out=%b%b expected %b%b", b, out_valid, out, exp_ov, exp_out);
      else n_pass++;
    end
    cfg_valid = 1'b0;
    n_checks++;
    if ({cfg_done, out} !== {1'b1, old_bit})
      $display("FAIL commit_edge_old: done/out=%b%b expected 1%b", cfg_done, out, old_bit);
    else n_pass++;
    tick();
    n_checks++;
    if (out !== pat[a]) $display("FAIL commit_next_new: out=%b expected %b", out, pat[a]);
    else n_pass++;
    eval_en = 1'b0;
  endtask

  task automatic test_simultaneous_and_partial_reset();
    int nb;
    int bad;
    nb = (D > 8) ? 7 : D - 1;
    bad = 0;
    cfg_valid = 1'b1;
    cfg_bit = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int b = 1; b < nb + D + 2; b++) begin
      cfg_valid = (b < nb);
      cfg_bit = 1'b1;
      tick();
      if (sweep_valid !== 1'b0 || sweep_busy !== 1'b0 || cfg_done !== 1'b0 || cfg_ready !== 1'b1) bad++;
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL simultaneous_no_sweep: %0d bad cycles expected 0", bad);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_done, sweep_valid, cfg_ready} !== 3'b001)
      $display("FAIL partial_reset_outs: done/valid/ready=%b%b%b expected 001", cfg_done, sweep_valid, cfg_ready);
    else n_pass++;
    do_reset();
    test_sweep("sweep_after_partial", 0);
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    bad = 0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sweep_busy, sweep_valid, sweep_bit, sweep_done, sweep_addr} !== {4'b0000, {N{1'b0}}})
      $display("FAIL midsweep_reset: busy/valid/bit/done=%b%b%b%b addr=%0d expected 0000 addr 0",
               sweep_busy, sweep_valid, sweep_bit, sweep_done, sweep_addr);
    else n_pass++;
    do_reset();
    for (int c = 0; c < D + 2; c++) begin
      tick();
      if (sweep_done !== 1'b0 || sweep_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL midsweep_no_done: %0d bad cycles expected 0", bad);
    else n_pass++;
  endtask

  initial begin
    logic [255:0] pat_6600, pat_0110, pat_alt, pat_rnd;
    pat_6600 = 256'h6600;
    pat_0110 = 256'h6;
    pat_alt  = {64{4'h5}};
    for (int i = 0; i < 8; i++) pat_rnd[i*32 +: 32] = $urandom;

    test_reset();
    test_sweep("sweep_after_reset", 0);
    test_eval_random("eval_zero", 2 * D);
    test_load(pat_6600, "load_6600");
    test_sweep("sweep_6600", 1);
    do_reset();
    test_commit_boundary(pat_6600);
    test_load(pat_0110, "load_0110");
    test_load(pat_alt, "load_alt");
    test_sweep("sweep_alt", 0);
    test_load(pat_rnd, "load_rnd");
    test_eval_random("eval_rnd", 3 * D);
    test_sweep("sweep_rnd", 1);
    test_simultaneous_and_partial_reset();
    test_load(pat_rnd, "reload_rnd");
    test_reset_mid_sweep();
    test_sweep("sweep_after_abort", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
